seven_seg_scan: RTL and testbench

Time-multiplexed driver for a multi-digit common-anode/common-cathode seven-segment display. Converts a packed hex value (one 4-bit nibble per digit) into segment patterns and scans the digits one at a time, with inter-digit blanking, per-digit decimal points, digit enables and leading-zero suppression. It sits between the register/switch logic and the board display pins. New values are buffered so each displayed frame is tear-free.

---
 rtl/seven_seg_scan.sv | 189 ++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment driver with tear-free shadowed display data.
// Outputs are registered one cycle behind the scan state; there is no backpressure.
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
    input  logic                      load,
    output logic [6:0]                segments,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic                      frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             SEG_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic             AN_INV     = (AN_ACTIVE_LOW != 0);

    typedef enum logic {
        S_GAP  = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     boundary;

    logic [4*NUM_DIGITS-1:0]  stg_val_q, shd_val_q;
    logic [NUM_DIGITS-1:0]    stg_dp_q, shd_dp_q;
    logic [NUM_DIGITS-1:0]    stg_en_q, shd_en_q;
    logic                     pend_q;

    logic                     wrap_q;
    logic [6:0]               seg_q;
    logic                     dp_q;
    logic [NUM_DIGITS-1:0]    an_q;
    logic                     fd_q;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            S_GAP: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Suppression runs from the top digit down while nibbles stay zero; digit 0 is exempt.
    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_above;
    always_comb begin
        supp       = '0;
        zero_above = lz_blank;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (shd_val_q[4*i +: 4] == 4'h0);
            supp[i]    = zero_above;
        end
    end

    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_lit;
    logic [NUM_DIGITS-1:0] an_act;
    logic [6:0]            seg_act;
    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_lit = 1'b0;
        an_act  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib   = shd_val_q[4*i +: 4];
                sel_dp    = shd_dp_q[i];
                sel_lit   = (state_q == S_SHOW) && shd_en_q[i] && !supp[i];
                an_act[i] = sel_lit;
            end
        end
        seg_act = sel_lit ? glyph(sel_nib) : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_GAP;
            cnt_q     <= '0;
            idx_q     <= '0;
            stg_val_q <= '0;
            stg_dp_q  <= '0;
            stg_en_q  <= '0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            shd_en_q  <= '0;
            pend_q    <= 1'b0;
            wrap_q    <= 1'b0;
            seg_q     <= {7{SEG_INV}};
            dp_q      <= SEG_INV;
            an_q      <= {NUM_DIGITS{AN_INV}};
            fd_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load) begin
                stg_val_q <= value;
                stg_dp_q  <= dp_in;
                stg_en_q  <= digit_en;
            end
            // A load landing on the boundary bypasses staging so it is not a frame late.
            if (boundary) begin
                pend_q <= 1'b0;
                if (load) begin
                    shd_val_q <= value;
                    shd_dp_q  <= dp_in;
                    shd_en_q  <= digit_en;
                end else if (pend_q) begin
                    shd_val_q <= stg_val_q;
                    shd_dp_q  <= stg_dp_q;
                    shd_en_q  <= stg_en_q;
                end
            end else if (load) begin
                pend_q <= 1'b1;
            end
            wrap_q <= boundary;
            seg_q  <= SEG_INV ? ~seg_act : seg_act;
            dp_q   <= SEG_INV ? ~(sel_lit & sel_dp) : (sel_lit & sel_dp);
            an_q   <= AN_INV ? ~an_act : an_act;
            fd_q   <= wrap_q;
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anodes     = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized scoreboard bench for seven_seg_scan against a slot-arithmetic display model.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int B     = 1;
    localparam int SLOT  = B + S;
    localparam int FRAME = N * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    digit_en = '0;
    logic          lz_blank = 1'b0;
    logic          load = 1'b0;
    logic [6:0]    segments;
    logic          dp;
    logic [3:0]    anodes;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    exp_t sb_q[$];

    logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0] m_stg_val, m_shd_val;
    logic [3:0]  m_stg_dp, m_shd_dp, m_stg_en, m_shd_en;
    logic        m_pend;

    seven_seg_scan #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .load(load), .segments(segments), .dp(dp),
        .anodes(anodes), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // What the pins show for scan position e (edge index since reset release).
    function automatic exp_t model_out(input int e);
        exp_t       x;
        int         r, d, ph;
        logic [3:0] nb;
        logic       sup;
        r  = e % FRAME;
        d  = r / SLOT;
        ph = r % SLOT;
        x.fd  = (e > 0) && (r == 0);
        x.an  = 4'hF;
        x.seg = 7'h7F;
        x.dp  = 1'b1;
        nb  = 4'(m_shd_val >> (4 * d));
        sup = lz_blank && (d > 0) && ((m_shd_val >> (4 * d)) == 16'h0);
        if (ph >= B && m_shd_en[d] && !sup) begin
            x.an  = ~(4'b0001 << d);
            x.seg = ~GLYPH[nb];
            x.dp  = ~m_shd_dp[d];
        end
        return x;
    endfunction

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (rst) begin
                x = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
                sb_q.push_back(x);
                m_stg_val = '0; m_stg_dp = '0; m_stg_en = '0;
                m_shd_val = '0; m_shd_dp = '0; m_shd_en = '0;
                m_pend    = 1'b0;
                edge_cnt  = 0;
            end else begin
                sb_q.push_back(model_out(edge_cnt));
                if ((edge_cnt % FRAME) == FRAME - 1) begin
                    if (load) begin
                        m_shd_val = value; m_shd_dp = dp_in; m_shd_en = digit_en;
                    end else if (m_pend) begin
                        m_shd_val = m_stg_val; m_shd_dp = m_stg_dp; m_shd_en = m_stg_en;
                    end
                    m_pend = 1'b0;
                end else if (load) begin
                    m_pend = 1'b1;
                end
                if (load) begin
                    m_stg_val = value; m_stg_dp = dp_in; m_stg_en = digit_en;
                end
                edge_cnt = edge_cnt + 1;
            end
        end
    end

    initial begin
        exp_t ex, got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                ex  = sb_q.pop_front();
                got = '{an: anodes, seg: segments, dp: dp, fd: frame_done};
                checks = checks + 1;
                if (got !== ex) begin
                    errors = errors + 1;
                    $display("FAIL pins t=%0t: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                             $time, got.an, got.seg, got.dp, got.fd, ex.an, ex.seg, ex.dp, ex.fd);
                end
                checks = checks + 1;
                if ($countones(~anodes) > 1) begin
                    errors = errors + 1;
                    $display("FAIL onehot t=%0t: anodes=%b, want at most one low", $time, anodes);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
        value    = v;
        dp_in    = d;
        digit_en = en;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_pos(input int m);
        for (int i = 0; i < FRAME && (edge_cnt % FRAME) != m; i++) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rv;
        cycles(3);
        rst = 1'b0;
        cycles(FRAME);

        // every glyph, four digits at a time
        for (int k = 0; k < 4; k++) begin
            rv = 16'h3210 + 16'(k) * 16'h4444;
            do_load(rv, 4'h0, 4'hF);
            cycles(2 * FRAME);
        end

        // tear-free: load while digit 1 is lit, then on the boundary edge itself
        do_load(16'h1111, 4'h0, 4'hF);
        cycles(2 * FRAME);
        wait_pos(SLOT + B + 1);
        do_load(16'h2222, 4'h0, 4'hF);
        cycles(2 * FRAME);
        wait_pos(FRAME - 1);
        do_load(16'h3333, 4'hA, 4'hF);
        cycles(2 * FRAME);

        // leading zeros
        lz_blank = 1'b1;
        do_load(16'h0042, 4'hF, 4'hF);
        cycles(2 * FRAME);
        do_load(16'h0000, 4'h0, 4'hF);
        cycles(2 * FRAME);
        lz_blank = 1'b0;

        // masking and decimal points
        do_load(16'h89AB, 4'b0100, 4'b0101);
        cycles(3 * FRAME);

        // random loads at random times
        for (int k = 0; k < 30; k++) begin
            rv       = 16'($urandom);
            rv       = rv >> (4 * $urandom_range(0, 4));
            lz_blank = 1'($urandom_range(0, 1));
            do_load(rv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cycles($urandom_range(1, 45));
        end

        // reset in the middle of digit 2, with a load pending
        do_load(16'h5678, 4'hF, 4'hF);
        cycles(2 * FRAME);
        do_load(16'h9999, 4'h0, 4'hF);
        wait_pos(2 * SLOT + B + 1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2 * FRAME);
        do_load(16'hC0DE, 4'h1, 4'hF);
        cycles(2 * FRAME);

        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
